// File: rtl/imem_loader.sv
// Boot loader: packs a UART byte stream (SYNC, count_lo, count_hi, data) into
// 32-bit words, writes them to instruction memory and then releases the CPU.
module imem_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              sysclk,
  input  logic              rstd,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstd,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   loaded_words
);

  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [16:0]   MAX_N    = 17'(1 << ADDR_W);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_cnt_lo;
  logic [15:0]       r_count;
  logic [1:0]        r_idx;
  logic [23:0]       r_buf;
  logic [ADDR_W-1:0] r_widx;
  logic [TW-1:0]     r_tmo;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_cpu_rstd;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   r_words;

  logic [15:0] w_n;
  logic        w_sync;
  logic        w_n_big;
  logic        w_active;
  logic        w_tmo;
  logic        w_last_wr;
  logic        w_start;
  logic        w_take;
  logic        w_word_done;
  logic        w_err_set;
  logic        w_load_data;
  logic        w_nxt_active;

  assign w_n       = {rx_data, r_cnt_lo};
  assign w_sync    = rx_valid && (rx_data == SYNC);
  assign w_n_big   = {1'b0, w_n} > MAX_N;
  assign w_active  = (r_state == CNT_LO) || (r_state == CNT_HI) || (r_state == DATA);
  assign w_tmo     = w_active && !rx_valid && (r_tmo == TMO_LAST);
  // The final write is in flight when its count matches N; DONE follows it by one cycle.
  assign w_last_wr = r_we && (17'(r_words) == {1'b0, r_count});

  always_ff @(posedge sysclk) begin
    if (rstd) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (w_sync) w_state_nxt = CNT_LO;
      CNT_LO: begin
        if (rx_valid)   w_state_nxt = CNT_HI;
        else if (w_tmo) w_state_nxt = IDLE;
      end
      CNT_HI: begin
        if (rx_valid) begin
          if (w_n == '0)   w_state_nxt = DONE;
          else if (w_n_big) w_state_nxt = IDLE;
          else             w_state_nxt = DATA;
        end else if (w_tmo) begin
          w_state_nxt = IDLE;
        end
      end
      DATA: begin
        if (w_last_wr)  w_state_nxt = DONE;
        else if (w_tmo) w_state_nxt = IDLE;
      end
      DONE:   if (w_sync) w_state_nxt = CNT_LO;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_start      = w_sync && ((r_state == IDLE) || (r_state == DONE));
    w_take       = (r_state == DATA) && rx_valid && !w_last_wr;
    w_word_done  = w_take && (r_idx == 2'd3);
    w_err_set    = ((r_state == CNT_HI) && rx_valid && w_n_big) || (w_tmo && !w_last_wr);
    w_load_data  = (r_state == CNT_HI) && (w_state_nxt == DATA);
    w_nxt_active = (w_state_nxt == CNT_LO) || (w_state_nxt == CNT_HI) || (w_state_nxt == DATA);
  end

  always_ff @(posedge sysclk) begin
    if (rstd) begin
      r_cnt_lo   <= '0;
      r_count    <= '0;
      r_idx      <= '0;
      r_buf      <= '0;
      r_widx     <= '0;
      r_tmo      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_rstd <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_words    <= '0;
    end else begin
      r_we       <= w_word_done;
      r_done     <= (w_state_nxt == DONE);
      r_cpu_rstd <= (w_state_nxt == DONE);
      r_tmo      <= (!w_nxt_active || rx_valid) ? '0 : r_tmo + 1'b1;

      if (w_start) begin
        r_err   <= 1'b0;
        r_words <= '0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end

      if ((r_state == CNT_LO) && rx_valid) r_cnt_lo <= rx_data;
      if ((r_state == CNT_HI) && rx_valid) r_count  <= w_n;

      if (w_load_data) begin
        r_idx  <= '0;
        r_widx <= '0;
        r_buf  <= '0;
      end else if (w_take) begin
        r_idx <= r_idx + 2'd1;
        case (r_idx)
          2'd0:    r_buf[7:0]   <= rx_data;
          2'd1:    r_buf[15:8]  <= rx_data;
          2'd2:    r_buf[23:16] <= rx_data;
          default: ;
        endcase
        if (w_word_done) begin
          r_wdata <= {rx_data, r_buf};
          r_addr  <= r_widx;
          r_widx  <= r_widx + 1'b1;
          r_words <= r_words + 1'b1;
        end
      end
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign cpu_rstd     = r_cpu_rstd;
  assign done         = r_done;
  assign err          = r_err;
  assign loaded_words = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, packing, overflow, timeout, reload
// and mid-load reset, with writes captured from the memory port.
module tb_imem_loader;

  logic        sysclk = 1'b0;
  logic        rstd;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rstd;
  logic        done;
  logic        err;
  logic [8:0]  loaded_words;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wr_n  = 0;
  logic [7:0]  wr_addr [300];
  logic [31:0] wr_data [300];

  imem_loader #(.ADDR_W(8), .SYNC(8'hA5), .TIMEOUT(16)) dut (
    .sysclk(sysclk), .rstd(rstd), .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rstd(cpu_rstd), .done(done), .err(err), .loaded_words(loaded_words)
  );

  always #5 sysclk = ~sysclk;

  always @(negedge sysclk) begin
    if (imem_we === 1'b1) begin
      if (wr_n < 300) begin
        wr_addr[wr_n] = imem_addr;
        wr_data[wr_n] = imem_wdata;
      end
      wr_n = wr_n + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge sysclk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge sysclk); #1; end
  endtask

  task automatic test_reset;
    rstd = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
    repeat (3) begin @(posedge sysclk); #1; end
    rx_valid = 1'b0; rstd = 1'b0;
    n_cmp++; if ({imem_we, cpu_rstd, done, err} !== 4'b0) begin n_bad++;
      $display("FAIL reset_flags: got we/cpu/done/err=%b required 0000", {imem_we, cpu_rstd, done, err}); end
    n_cmp++; if ({imem_addr, imem_wdata, loaded_words} !== '0) begin n_bad++;
      $display("FAIL reset_buses: got addr=%h wdata=%h words=%0d required 0", imem_addr, imem_wdata, loaded_words); end
    // still IDLE: a zero count would reach DONE if SYNC had been taken during reset
    send_byte(8'h00); send_byte(8'h00); idle(2);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_idle: got done=%b required 0", done); end
    n_cmp++; if (wr_n !== 0) begin n_bad++; $display("FAIL reset_nowrite: got %0d writes required 0", wr_n); end
  endtask

  task automatic test_junk;
    logic [7:0] seq [10] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
    wr_n = 0;
    foreach (seq[i]) begin send_byte(seq[i]); idle(1); end
    idle(2);
    n_cmp++; if (wr_n !== 1) begin n_bad++; $display("FAIL junk_count: got %0d writes required 1", wr_n); end
    n_cmp++; if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h01020304) begin n_bad++;
      $display("FAIL junk_word: got addr=%h data=%h required 00/01020304", wr_addr[0], wr_data[0]); end
    n_cmp++; if ({done, cpu_rstd, err} !== 3'b110 || loaded_words !== 9'd1) begin n_bad++;
      $display("FAIL junk_done: got done/cpu/err=%b words=%0d required 110/1", {done, cpu_rstd, err}, loaded_words); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq [11] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wr_n = 0;
    foreach (seq[i]) send_byte(seq[i]);
    n_cmp++; if ({imem_we, done} !== 2'b10) begin n_bad++;
      $display("FAIL b2b_lastwr: got we/done=%b required 10", {imem_we, done}); end
    idle(1);
    n_cmp++; if ({imem_we, done, cpu_rstd} !== 3'b011) begin n_bad++;
      $display("FAIL b2b_release: got we/done/cpu=%b required 011", {imem_we, done, cpu_rstd}); end
    idle(2);
    n_cmp++; if (wr_n !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d writes required 2", wr_n); end
    n_cmp++; if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h12345678) begin n_bad++;
      $display("FAIL b2b_word0: got addr=%h data=%h required 00/12345678", wr_addr[0], wr_data[0]); end
    n_cmp++; if (wr_addr[1] !== 8'h01 || wr_data[1] !== 32'hDEADBEEF) begin n_bad++;
      $display("FAIL b2b_word1: got addr=%h data=%h required 01/deadbeef", wr_addr[1], wr_data[1]); end
    n_cmp++; if (loaded_words !== 9'd2 || err !== 1'b0) begin n_bad++;
      $display("FAIL b2b_words: got words=%0d err=%b required 2/0", loaded_words, err); end
  endtask

  task automatic test_overflow;
    logic [7:0] bw;
    logic [31:0] expw;
    wr_n = 0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    idle(1);
    n_cmp++; if ({err, done, cpu_rstd} !== 3'b100) begin n_bad++;
      $display("FAIL ovf_err: got err/done/cpu=%b required 100", {err, done, cpu_rstd}); end
    send_byte(8'hA5);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ovf_errclr: got err=%b required 0", err); end
    send_byte(8'h00); send_byte(8'h01);
    for (int w = 0; w < 256; w++) begin
      bw = 8'(w);
      send_byte(8'h3C); send_byte(bw + 8'h11); send_byte(~bw); send_byte(bw);
    end
    idle(3);
    n_cmp++; if (wr_n !== 256) begin n_bad++; $display("FAIL full_count: got %0d writes required 256", wr_n); end
    for (int w = 0; w < 256; w++) begin
      bw = 8'(w);
      expw = {bw, ~bw, bw + 8'h11, 8'h3C};
      n_cmp++; if (wr_addr[w] !== bw || wr_data[w] !== expw) begin n_bad++;
        $display("FAIL full_word%0d: got addr=%h data=%h required %h/%h", w, wr_addr[w], wr_data[w], bw, expw); end
    end
    n_cmp++; if ({done, cpu_rstd, err} !== 3'b110 || loaded_words !== 9'd256) begin n_bad++;
      $display("FAIL full_done: got done/cpu/err=%b words=%0d required 110/256", {done, cpu_rstd, err}, loaded_words); end
  endtask

  task automatic test_timeout;
    wr_n = 0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    idle(15);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got err=%b required 0 after 15 idle", err); end
    idle(1);
    n_cmp++; if ({err, cpu_rstd, done} !== 3'b100) begin n_bad++;
      $display("FAIL tmo_err: got err/cpu/done=%b required 100", {err, cpu_rstd, done}); end
    send_byte(8'hA5);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL tmo_clr: got err=%b required 0", err); end
    send_byte(8'h00); send_byte(8'h00);
    n_cmp++; if ({done, cpu_rstd} !== 2'b11 || loaded_words !== 9'd0 || wr_n !== 0) begin n_bad++;
      $display("FAIL zero_count: got done/cpu=%b words=%0d writes=%0d required 11/0/0", {done, cpu_rstd}, loaded_words, wr_n); end
  endtask

  task automatic test_reload;
    wr_n = 0;
    send_byte(8'hA5);
    n_cmp++; if ({cpu_rstd, done} !== 2'b00) begin n_bad++;
      $display("FAIL reload_hold: got cpu/done=%b required 00", {cpu_rstd, done}); end
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    idle(3);
    n_cmp++; if (wr_n !== 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'hDDCCBBAA) begin n_bad++;
      $display("FAIL reload_word: got n=%0d addr=%h data=%h required 1/00/ddccbbaa", wr_n, wr_addr[0], wr_data[0]); end
    n_cmp++; if ({done, cpu_rstd} !== 2'b11 || loaded_words !== 9'd1) begin n_bad++;
      $display("FAIL reload_done: got done/cpu=%b words=%0d required 11/1", {done, cpu_rstd}, loaded_words); end
    wr_n = 0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
    rstd = 1'b1; idle(1); rstd = 1'b0;
    send_byte(8'hCC); send_byte(8'hDD);
    idle(3);
    n_cmp++; if (wr_n !== 0) begin n_bad++; $display("FAIL rst_mid_write: got %0d writes required 0", wr_n); end
    n_cmp++; if ({cpu_rstd, done, err} !== 3'b000 || loaded_words !== 9'd0) begin n_bad++;
      $display("FAIL rst_mid_state: got cpu/done/err=%b words=%0d required 000/0", {cpu_rstd, done, err}, loaded_words); end
  endtask

  initial begin
    rstd = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    @(posedge sysclk); #1;
    test_reset;
    test_junk;
    test_back_to_back;
    test_overflow;
    test_timeout;
    test_reload;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
